// File: rtl/velocity_frame_rotator_if.sv
// Handshake and data bundle of the velocity frame rotator.
//
// Handshake: the requester raises `start` with the operands on the bus. The
// rotator samples them only while idle (`busy`=0). `busy` is high while an
// operation is in flight, and any `start` seen then is dropped. `done` is a
// single-cycle strobe: on that cycle res_* and the two flags are newly
// updated. Between strobes they hold their values.
//
// All data buses are sign-magnitude with Q fractional bits.
// Operands: vx, vy [m/s], wz [rad/s], theta [deg], mode (0: +theta, 1: -theta).
// Results: res_vx, res_vy (rotated), res_wz (wz as captured).
// Flags: overflow (a result saturated), angle_err (|theta| >= 360 deg).
interface velocity_frame_rotator_if #(
  parameter int N_WIDTH = 32
);
  logic               start;
  logic               mode;
  logic [N_WIDTH-1:0] vx;
  logic [N_WIDTH-1:0] vy;
  logic [N_WIDTH-1:0] wz;
  logic [N_WIDTH-1:0] theta;
  logic               busy;
  logic               done;
  logic               overflow;
  logic               angle_err;
  logic [N_WIDTH-1:0] res_vx;
  logic [N_WIDTH-1:0] res_vy;
  logic [N_WIDTH-1:0] res_wz;

  modport master (
    output start, mode, vx, vy, wz, theta,
    input  busy, done, overflow, angle_err, res_vx, res_vy, res_wz
  );

  modport slave (
    input  start, mode, vx, vy, wz, theta,
    output busy, done, overflow, angle_err, res_vx, res_vy, res_wz
  );
endinterface

// File: rtl/velocity_frame_rotator.sv
// Rotates a planar velocity by theta (degrees, any |theta| < 360) with an
// iterative CORDIC: mode 0 maps local->global (+theta), mode 1 maps
// global->local (-theta). The angle is first folded to a quadrant and a
// 0..90 deg residual. The residual is rotated one micro-step per clock. The
// products are then formed in one cycle, and the sums are saturated in the next.
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous, active-high reset; aborts any operation
//   bus       - slave side of velocity_frame_rotator_if (operands, results, flags)
//   state_dbg - current FSM state (0 IDLE, 1 ROTATE, 2 MULT, 3 SUM)
module velocity_frame_rotator #(
  parameter int N_WIDTH     = 32,
  parameter int Q_WIDTH     = 15,
  parameter int CORDIC_ITER = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  velocity_frame_rotator_if.slave bus,
  output logic [1:0]              state_dbg
);
  localparam int CW   = Q_WIDTH + 2;       // CORDIC x/y width, two's complement
  localparam int AW   = N_WIDTH + 1;       // angle accumulator width
  localparam int VW   = N_WIDTH + 1;       // signed form of a sign-magnitude bus
  localparam int PW   = VW + CW;           // full product width
  localparam int PRW  = PW - Q_WIDTH;      // product after dropping Q fraction bits
  localparam int SMW  = PRW + 1;           // sum width
  localparam int IW   = $clog2(CORDIC_ITER);
  // Table and gain constants are stored at 15 fraction bits and rescaled.
  localparam int SH_L = (Q_WIDTH > 15) ? Q_WIDTH - 15 : 0;
  localparam int SH_R = (Q_WIDTH < 15) ? 15 - Q_WIDTH : 0;

  localparam logic [63:0]          K_Q15   = 64'd19898;  // 1/1.6468
  localparam logic signed [CW-1:0] K_INIT  = CW'((K_Q15 << SH_L) >> SH_R);
  localparam logic [AW-1:0]        DEG90   = AW'(90) << Q_WIDTH;
  localparam logic [AW-1:0]        DEG180  = AW'(180) << Q_WIDTH;
  localparam logic [AW-1:0]        DEG270  = AW'(270) << Q_WIDTH;
  localparam logic [AW-1:0]        DEG360  = AW'(360) << Q_WIDTH;
  localparam logic [SMW-1:0]       MAX_MAG = SMW'({(N_WIDTH-1){1'b1}});

  typedef enum logic [1:0] {IDLE = 2'd0, ROTATE = 2'd1, MULT = 2'd2, SUM = 2'd3} state_t;
  state_t state, state_n;

  logic signed [VW-1:0]  vx_r, vy_r;
  logic [N_WIDTH-1:0]    wz_r;
  logic                  mode_r, err_r;
  logic [1:0]            quad_r;
  logic signed [CW-1:0]  x_r, y_r;
  logic signed [AW-1:0]  z_r;
  logic [IW-1:0]         iter_r;
  logic signed [PRW-1:0] p_xc, p_ys, p_xs, p_yc;
  logic [N_WIDTH-1:0]    vx_o, vy_o, wz_o;
  logic                  done_o, ovf_o, aerr_o;

  logic [AW-1:0]         mag_c, t_c, res_c;
  logic                  angle_bad;
  logic [1:0]            quad_c;
  logic signed [CW-1:0]  rnd, x_sh, y_sh, x_n, y_n, cos_t, sin_t;
  logic signed [AW-1:0]  z_n;
  logic signed [SMW-1:0] sum_x, sum_y;
  logic [N_WIDTH:0]      sat_x, sat_y;

  // atan(2^-i) in degrees.
  function automatic logic signed [AW-1:0] atan_deg(input logic [IW-1:0] i);
    logic [63:0] a;
    case (int'(i))
      0:  a = 64'd1474560;
      1:  a = 64'd870484;
      2:  a = 64'd459940;
      3:  a = 64'd233473;
      4:  a = 64'd117189;
      5:  a = 64'd58652;
      6:  a = 64'd29333;
      7:  a = 64'd14667;
      8:  a = 64'd7334;
      9:  a = 64'd3667;
      10: a = 64'd1833;
      11: a = 64'd917;
      12: a = 64'd458;
      13: a = 64'd229;
      14: a = 64'd115;
      15: a = 64'd57;
      default: a = 64'd0;
    endcase
    return signed'(AW'((a << SH_L) >> SH_R));
  endfunction

  function automatic logic signed [VW-1:0] sm_to_s(input logic [N_WIDTH-1:0] v);
    logic [VW-1:0] mag;
    mag = {2'b00, v[N_WIDTH-2:0]};
    return v[N_WIDTH-1] ? -signed'(mag) : signed'(mag);
  endfunction

  // Returns {overflow, sign, magnitude}. A zero magnitude is always positive.
  function automatic logic [N_WIDTH:0] sat_sm(input logic signed [SMW-1:0] s);
    logic [SMW-1:0]     mag;
    logic               ovf;
    logic [N_WIDTH-2:0] m;
    mag = s[SMW-1] ? SMW'(-s) : SMW'(s);
    ovf = (mag > MAX_MAG);
    m   = ovf ? '1 : mag[N_WIDTH-2:0];
    return {ovf, s[SMW-1] && (m != '0), m};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = angle_bad ? SUM : ROTATE;
      ROTATE:  if (iter_r == IW'(CORDIC_ITER - 1)) state_n = MULT;
      MULT:    state_n = SUM;
      SUM:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    // Angle folding: negative angles get +360, then quadrant and residual.
    mag_c     = {2'b00, bus.theta[N_WIDTH-2:0]};
    angle_bad = (mag_c >= DEG360);
    t_c       = (bus.theta[N_WIDTH-1] && (mag_c != '0)) ? DEG360 - mag_c : mag_c;
    quad_c    = 2'd0;
    res_c     = t_c;
    if (t_c >= DEG270) begin
      quad_c = 2'd3;
      res_c  = t_c - DEG270;
    end else if (t_c >= DEG180) begin
      quad_c = 2'd2;
      res_c  = t_c - DEG180;
    end else if (t_c >= DEG90) begin
      quad_c = 2'd1;
      res_c  = t_c - DEG90;
    end

    // Micro-rotation. Shifts round to nearest so truncation error does not
    // build up a bias over the iterations.
    rnd = '0;
    if (iter_r != '0) rnd = signed'(CW'(1) << (iter_r - IW'(1)));
    x_sh = (x_r + rnd) >>> iter_r;
    y_sh = (y_r + rnd) >>> iter_r;
    if (!z_r[AW-1]) begin
      x_n = x_r - y_sh;
      y_n = y_r + x_sh;
      z_n = z_r - atan_deg(iter_r);
    end else begin
      x_n = x_r + y_sh;
      y_n = y_r - x_sh;
      z_n = z_r + atan_deg(iter_r);
    end

    // Map (cos r, sin r) onto the full-circle angle.
    case (quad_r)
      2'd0:    begin cos_t = x_r;  sin_t = y_r;  end
      2'd1:    begin cos_t = -y_r; sin_t = x_r;  end
      2'd2:    begin cos_t = -x_r; sin_t = -y_r; end
      default: begin cos_t = y_r;  sin_t = -x_r; end
    endcase
    if (mode_r) sin_t = -sin_t;

    sum_x = SMW'(p_xc) - SMW'(p_ys);
    sum_y = SMW'(p_xs) + SMW'(p_yc);
    sat_x = sat_sm(sum_x);
    sat_y = sat_sm(sum_y);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vx_r <= '0; vy_r <= '0; wz_r <= '0; mode_r <= 1'b0; err_r <= 1'b0;
      quad_r <= '0; x_r <= '0; y_r <= '0; z_r <= '0; iter_r <= '0;
      p_xc <= '0; p_ys <= '0; p_xs <= '0; p_yc <= '0;
      vx_o <= '0; vy_o <= '0; wz_o <= '0;
      done_o <= 1'b0; ovf_o <= 1'b0; aerr_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            vx_r   <= sm_to_s(bus.vx);
            vy_r   <= sm_to_s(bus.vy);
            wz_r   <= bus.wz;
            mode_r <= bus.mode;
            err_r  <= angle_bad;
            quad_r <= quad_c;
            z_r    <= signed'(res_c);
            x_r    <= K_INIT;
            y_r    <= '0;
            iter_r <= '0;
          end
        end
        ROTATE: begin
          x_r    <= x_n;
          y_r    <= y_n;
          z_r    <= z_n;
          iter_r <= iter_r + IW'(1);
        end
        MULT: begin
          p_xc <= PRW'((PW'(vx_r) * PW'(cos_t)) >>> Q_WIDTH);
          p_ys <= PRW'((PW'(vy_r) * PW'(sin_t)) >>> Q_WIDTH);
          p_xs <= PRW'((PW'(vx_r) * PW'(sin_t)) >>> Q_WIDTH);
          p_yc <= PRW'((PW'(vy_r) * PW'(cos_t)) >>> Q_WIDTH);
        end
        SUM: begin
          done_o <= 1'b1;
          if (err_r) begin
            // Bad angle: results keep their previous values.
            aerr_o <= 1'b1;
            ovf_o  <= 1'b0;
          end else begin
            vx_o   <= sat_x[N_WIDTH-1:0];
            vy_o   <= sat_y[N_WIDTH-1:0];
            wz_o   <= wz_r;
            ovf_o  <= sat_x[N_WIDTH] | sat_y[N_WIDTH];
            aerr_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_o;
  assign bus.overflow  = ovf_o;
  assign bus.angle_err = aerr_o;
  assign bus.res_vx    = vx_o;
  assign bus.res_vy    = vy_o;
  assign bus.res_wz    = wz_o;
  assign state_dbg     = state;
endmodule

// File: tb/tb_velocity_frame_rotator.sv
// Directed bench for velocity_frame_rotator. The driver pushes hand-computed
// expectations into exp_q when an operation is accepted, and the monitor pops
// and compares on every done strobe.
module tb_velocity_frame_rotator;
  localparam int N  = 32;
  localparam int Q  = 15;
  localparam int IT = 16;

  typedef struct {
    logic [N-1:0] vx;
    logic [N-1:0] vy;
    logic [N-1:0] wz;
    logic         ovf;
    logic         aerr;
    int           tol_x;
    int           tol_y;
    int           lat;
    int           acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         accept_cyc = 0;
  exp_t       exp_q[$];

  velocity_frame_rotator_if #(.N_WIDTH(N)) bus ();

  velocity_frame_rotator #(.N_WIDTH(N), .Q_WIDTH(Q), .CORDIC_ITER(IT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic longint sm2i(input logic [N-1:0] v);
    longint m;
    m = longint'(v[N-2:0]);
    return v[N-1] ? -m : m;
  endfunction

  task automatic chk_near(input string nm, input logic [N-1:0] act,
                          input logic [N-1:0] req, input int tol);
    longint d;
    d = sm2i(act) - sm2i(req);
    if (d < 0) d = -d;
    checks++;
    if (d > longint'(tol)) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (+-%0d)", nm, act, req, tol);
    end
  endtask

  task automatic chk_eq(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [N-1:0] vx, input logic [N-1:0] vy,
                       input logic [N-1:0] wz, input logic [N-1:0] th, input logic md);
    bus.vx = vx; bus.vy = vy; bus.wz = wz; bus.theta = th; bus.mode = md;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    bus.start = 1'b0;
  endtask

  // b2b=1: caller is already at the negedge of a done cycle.
  task automatic op(input logic [N-1:0] vx, input logic [N-1:0] vy,
                    input logic [N-1:0] wz, input logic [N-1:0] th, input logic md,
                    input logic [N-1:0] ex, input logic [N-1:0] ey, input logic [N-1:0] ew,
                    input logic eovf, input logic eaerr, input int tx, input int ty,
                    input bit b2b);
    exp_t e;
    if (!b2b) @(negedge clk);
    drive(vx, vy, wz, th, md);
    e.vx = ex; e.vy = ey; e.wz = ew; e.ovf = eovf; e.aerr = eaerr;
    e.tol_x = tx; e.tol_y = ty;
    e.lat = eaerr ? 1 : IT + 2;
    e.acc = accept_cyc;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 40);
    checks++;
    if (!bus.done) begin
      errors++;
      $display("FAIL done_timeout actual=0 required=1");
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 cycle=%0d", cyc);
      end else begin
        e = exp_q.pop_front();
        chk_near("vx_out", bus.res_vx, e.vx, e.tol_x);
        chk_near("vy_out", bus.res_vy, e.vy, e.tol_y);
        chk_eq("wz_out", bus.res_wz, e.wz);
        chk_eq("overflow", N'(bus.overflow), N'(e.ovf));
        chk_eq("angle_err", N'(bus.angle_err), N'(e.aerr));
        chk_eq("latency", N'(cyc - e.acc), N'(e.lat));
        chk_eq("busy_on_done", N'(bus.busy), '0);
        chk_eq("neg_zero", N'(bus.res_vx == 32'h80000000 || bus.res_vy == 32'h80000000), '0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int stray;
    bus.start = 1'b0; bus.mode = 1'b0;
    bus.vx = '0; bus.vy = '0; bus.wz = '0; bus.theta = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_vx", bus.res_vx, '0);
    chk_eq("rst_vy", bus.res_vy, '0);
    chk_eq("rst_wz", bus.res_wz, '0);
    chk_eq("rst_flags", N'({bus.busy, bus.done, bus.overflow, bus.angle_err}), '0);
    chk_eq("rst_state", N'(state_dbg), '0);
    rst = 1'b0;

    // theta=0: identity, 18-cycle latency
    op(32'h00008000, 32'h00004000, 32'h00000000, 32'h00000000, 1'b0,
       32'h00008000, 32'h00004000, 32'h00000000, 1'b0, 1'b0, 4, 4, 1'b0);
    drain();

    // theta=90: (1,0) -> (0,1), wz passes through
    op(32'h00008000, 32'h00000000, 32'h00002000, 32'h002D0000, 1'b0,
       32'h00000000, 32'h00008000, 32'h00002000, 1'b0, 1'b0, 4, 4, 1'b0);
    drain();

    // theta=-135: folds to 225 deg, quadrant 2
    op(32'h00008000, 32'h00000000, 32'h00000000, 32'h80438000, 1'b0,
       32'h80005A82, 32'h80005A82, 32'h00000000, 1'b0, 1'b0, 4, 4, 1'b0);
    drain();

    // Round trip at 30 deg; the reverse rotation starts on the done cycle.
    op(32'h00008000, 32'h00004000, 32'h80001000, 32'h000F0000, 1'b0,
       32'h00004EDA, 32'h0000776D, 32'h80001000, 1'b0, 1'b0, 4, 4, 1'b0);
    wait_done();
    op(32'h00004EDA, 32'h0000776D, 32'h80001000, 32'h000F0000, 1'b1,
       32'h00008000, 32'h00004000, 32'h80001000, 1'b0, 1'b0, 8, 8, 1'b1);
    drain();

    // Saturation at 45 deg with full-scale inputs
    op(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h12345678, 32'h00168000, 1'b0,
       32'h00000000, 32'h7FFFFFFF, 32'h12345678, 1'b1, 1'b0, 300000, 0, 1'b0);
    drain();

    // theta=+360 and -360: error, results unchanged, done next cycle
    op(32'h00008000, 32'h00008000, 32'h00001111, 32'h00B40000, 1'b0,
       32'h00000000, 32'h7FFFFFFF, 32'h12345678, 1'b0, 1'b1, 300000, 0, 1'b0);
    drain();
    op(32'h00008000, 32'h00008000, 32'h00001111, 32'h80B40000, 1'b1,
       32'h00000000, 32'h7FFFFFFF, 32'h12345678, 1'b0, 1'b1, 300000, 0, 1'b0);
    drain();

    // START while busy is dropped; inputs change after accept
    op(32'h00010000, 32'h80008000, 32'h00004000, 32'h00000000, 1'b0,
       32'h00010000, 32'h80008000, 32'h00004000, 1'b0, 1'b0, 8, 4, 1'b0);
    repeat (5) @(negedge clk);
    chk_eq("busy_mid", N'(bus.busy), N'(1'b1));
    bus.theta = 32'h002D0000; bus.vx = 32'h00008000; bus.mode = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // Reset in the middle of ROTATE: no done, everything cleared
    @(negedge clk);
    drive(32'h00008000, 32'h00004000, 32'h00002000, 32'h000F0000, 1'b0);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_eq("abort_vx", bus.res_vx, '0);
    chk_eq("abort_vy", bus.res_vy, '0);
    chk_eq("abort_wz", bus.res_wz, '0);
    chk_eq("abort_flags", N'({bus.busy, bus.done, bus.overflow, bus.angle_err}), '0);
    chk_eq("abort_state", N'(state_dbg), '0);
    rst = 1'b0;
    stray = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) stray++;
    end
    chk_eq("abort_no_done", N'(stray), '0);

    // Next operation after the abort: global->local by 90 deg
    op(32'h00008000, 32'h00000000, 32'h00000100, 32'h002D0000, 1'b1,
       32'h00000000, 32'h80008000, 32'h00000100, 1'b0, 1'b0, 4, 4, 1'b0);
    drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
